// File: rtl/fx_mac_vec.sv
`timescale 1ns/1ps
// fx_mac_vec: LANES-wide, frame-based fixed-point dot-product engine (K terms per frame)
// with truncate/RNE rounding and saturating narrowing. FX_MAC_SAT_FLAG_EN adds sat_o.
module fx_mac_vec #(
    parameter int WIDTH    = 8,
    parameter int FRACTION = 4,
    parameter int K        = 8,
    parameter int LANES    = 4,
    parameter int WK       = $clog2(K),
    localparam int WIDTH_A = 2*WIDTH + WK + 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sclr_i,
    input  logic                     vld_i,
    input  logic                     rnd_mode_i,
    input  logic [LANES*WIDTH-1:0]   win,
    input  logic [WIDTH-1:0]         din,
    output logic                     vld_o,
    output logic [LANES*WIDTH-1:0]   acc_o
`ifdef FX_MAC_SAT_FLAG_EN
    ,
    output logic [LANES-1:0]         sat_o
`endif
);
    localparam int WP = 2*WIDTH;
    localparam int RW = WIDTH_A - FRACTION + 1;
    localparam logic [WK-1:0]        CNT_LAST    = WK'(K-1);
    localparam logic [WIDTH_A-1:0]   STICKY_MASK = (WIDTH_A'(1) << (FRACTION-1)) - WIDTH_A'(1);
    localparam logic signed [RW-1:0] SAT_MAX     = (RW'(1) << (WIDTH-1)) - RW'(1);
    localparam logic signed [RW-1:0] SAT_MIN     = -(RW'(1) << (WIDTH-1));

    logic [WK-1:0]            cnt;
    logic                     s1_vld, s1_first, s1_last, s1_rnd;
    logic signed [WP-1:0]     mult [LANES];
    logic signed [WIDTH_A-1:0] acc [LANES];
    logic                     s2_vld, s2_rnd;
    logic signed [RW-1:0]     r_floor [LANES];
    logic signed [RW-1:0]     r_round [LANES];
    logic [LANES*WIDTH-1:0]   res_flat;
`ifdef FX_MAC_SAT_FLAG_EN
    logic [LANES-1:0]         clip;
`endif

    // Stage 1 control: frame position and flags travelling with the product.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            cnt      <= '0;
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_rnd   <= 1'b0;
        end else if (sclr_i) begin
            cnt    <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= vld_i;
            if (vld_i) begin
                s1_first <= (cnt == '0);
                s1_last  <= (cnt == CNT_LAST);
                s1_rnd   <= rnd_mode_i;
                cnt      <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    // NOTE: product registers carry no reset; they are only consumed when qualified by s1_vld.
    always_ff @(posedge clk) begin
        if (vld_i && !sclr_i) begin
            for (int l = 0; l < LANES; l++)
                mult[l] <= $signed(win[l*WIDTH +: WIDTH]) * $signed(din);
        end
    end

    // Stage 2: a first product loads the accumulator directly, so frames need no clear bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            s2_vld <= 1'b0;
            s2_rnd <= 1'b0;
        end else if (sclr_i) begin
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld & s1_last;
            if (s1_vld) begin
                s2_rnd <= s1_rnd;
                for (int l = 0; l < LANES; l++)
                    acc[l] <= s1_first ? WIDTH_A'(mult[l]) : acc[l] + WIDTH_A'(mult[l]);
            end
        end
    end

    // Stage 3 datapath: floor, optional round-half-to-even increment, then clip to WIDTH.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        res_flat = '0;
`ifdef FX_MAC_SAT_FLAG_EN
        clip = '0;
`endif
        for (int l = 0; l < LANES; l++) begin
            r_floor[l] = RW'(acc[l] >>> FRACTION);
            r_round[l] = r_floor[l] + RW'(s2_rnd & acc[l][FRACTION-1] &
                                          ((|(acc[l] & STICKY_MASK)) | acc[l][FRACTION]));
            if (r_round[l] > SAT_MAX)
                res_flat[l*WIDTH +: WIDTH] = WIDTH'(SAT_MAX);
            else if (r_round[l] < SAT_MIN)
                res_flat[l*WIDTH +: WIDTH] = WIDTH'(SAT_MIN);
            else
                res_flat[l*WIDTH +: WIDTH] = r_round[l][WIDTH-1:0];
`ifdef FX_MAC_SAT_FLAG_EN
            clip[l] = (r_round[l] > SAT_MAX) || (r_round[l] < SAT_MIN);
`endif
        end
    end

    // Output register: result holds until the next frame completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_o <= 1'b0;
            acc_o <= '0;
`ifdef FX_MAC_SAT_FLAG_EN
            sat_o <= '0;
`endif
        end else begin
            vld_o <= s2_vld;
            if (s2_vld) begin
                acc_o <= res_flat;
`ifdef FX_MAC_SAT_FLAG_EN
                sat_o <= clip;
`endif
            end
        end
    end

endmodule

// File: doc/fx_mac_vec.md
# fx_mac_vec

Multi-lane, frame-based fixed-point multiply-accumulate engine, successor to the single-lane free-running MAC. LANES parallel lanes each compute a K-term dot product of a per-lane weight stream against a shared data stream, with valid-qualified input, automatic frame counting, selectable rounding and saturating narrowing. It sits between the weight/activation feeders and the output buffer of the fixed-point datapath, producing one LANES-wide result word per K accepted samples.

## Interface
- WIDTH, 8: bitwidth of win/din lanes and of each output lane (signed, two's complement).
- FRACTION, 4: fractional bits of inputs and outputs; legal range 1..WIDTH-1.
- K, 8: products per dot product (frame length); K >= 2.
- LANES, 4: parallel output channels.
- WK, $clog2(K): frame counter width.
- WIDTH_A, 2*WIDTH+WK+1: accumulator width. Derived, never overridden.

- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- sclr_i  in  1  synchronous clear/abort of the current frame.
- vld_i  in  1  input sample valid.
- rnd_mode_i  in  1  0 = truncate (floor), 1 = round-half-to-even.
- win  in  LANES*WIDTH  per-lane weights; lane i = win[i*WIDTH +: WIDTH].
- din  in  WIDTH  shared data sample, broadcast to all lanes.
- vld_o  out  1  one-cycle result strobe.
- acc_o  out  LANES*WIDTH  per-lane results, same packing as win.

## Operation
- Stage 1, multiply: on vld_i, each lane registers win_i*din (2*WIDTH bits, 2*FRACTION fractional bits). Alongside it, registers valid, first flag (count==0), last flag (count==K-1) and rnd_mode_i.
- Frame counter: increments per accepted vld_i and wraps K-1 -> 0. Samples with vld_i=0 are ignored, with no state change. Gaps inside a frame are allowed.
- Stage 2, accumulate: a valid first product loads acc (acc <= mult, no clear bubble). Other valid products do acc <= acc + sign-extended mult. WIDTH_A cannot overflow for any K products.
- Stage 3, round/saturate: on the last product, compute r = acc >>> FRACTION with rounding.
  - Truncate: arithmetic shift, which floors.
  - RNE: g = acc[FRACTION-1], s = |acc[FRACTION-2:0] (0 when FRACTION=1), l = acc[FRACTION]; add 1 when g & (s | l).
  - Saturation: r > 2^(WIDTH-1)-1 gives max, r < -2^(WIDTH-1) gives min. Otherwise take the low WIDTH bits.
  - Results register into acc_o and vld_o pulses.
- rnd_mode is taken from the last sample of the frame.
- acc_o holds its value until the next result. vld_o is high for exactly one cycle per frame.
- sclr_i: zeroes the counter, stage-1/2 valid flags and acc. In-flight partial frames are discarded and no vld_o results from them. A result already in stage 3 still emits. If sclr_i and vld_i are high in the same cycle, that sample is dropped.

## Timing
- Reset: vld_o=0, acc_o=0, counter=0, acc=0, all pipeline valids=0.
- Latency: the last sample is accepted at edge E. The accumulate completes at E+1. acc_o/vld_o are valid after E+2, i.e. 3 cycles from sample to strobe.
- Throughput: one sample per cycle, no backpressure. Back-to-back frames give vld_o every K cycles.
- Reset asserted mid-frame: the partial frame is lost and the next accepted sample is frame position 0.

## Configuration
- FX_MAC_SAT_FLAG_EN defined: adds output sat_o [LANES-1:0].
  - Bit i is set with vld_o when lane i clipped.
  - It holds with acc_o and resets to 0.
- Undefined: the port and its logic are absent, and saturation behaviour is unchanged.

## Test plan
- Nominal, defaults: all win lanes 0x10 (1.0), din 0x08 (0.5), 8 consecutive valids -> vld_o once at cycle 3 after the last sample, every lane 0x40 (4.0).
- Positive saturation: win 0x10, din 0x10 ×8 -> sum 8.0 clips to 0x7F (sat_o=all 1s with macro). Negative: win 0x80, din 0x10 -> 0x80.
- Rounding: one product 0x03×0x08 (1.5 LSB), rest 0:
  - rnd_mode 0 -> 0x01; rnd_mode 1 -> 0x02.
  - 0x01×0x08 (0.5 LSB): both modes -> 0x00.
  - 0xFD×0x08 (-1.5 LSB): trunc -> 0xFE, RNE -> 0xFE.
- Gapped input: 8 valids spread over 20 cycles with random vld_i gaps -> same result as the nominal case, single vld_o.
- Back-to-back frames with different weights per frame -> vld_o every 8 cycles, each result independent (no carry-over from the previous acc).
- sclr_i after 5 samples, then a full frame -> exactly one vld_o, matching the new frame only. Async rstn mid-frame -> outputs 0 immediately and the counter restarts.
